spike_aer_tx: RTL and testbench
===============================

# spike_aer_tx

Spike event transmitter on the output side of the `neuron` model. Watches the neuron's membrane voltage, a fixed-point real in svreal raw format, once per emulator timestep. Detects threshold crossings with hysteresis and a refractory window. Emits timestamped address-event (AER) words over a valid/ready stream through a small first-word-fall-through (FWFT) FIFO, so downstream fabric or a host link can consume spikes.

## Interface
Parameters:
- `V_WIDTH`, 25, raw width of `v_in`; matches the svreal width of the neuron's `V_out`.
- `THRESH_HI`, 1000, signed raw value in `v_in` format. `v_in >= THRESH_HI` fires a spike.
- `THRESH_LO`, 200, signed raw value. `v_in <= THRESH_LO` re-arms the detector. Must be below `THRESH_HI`.
- `REFRAC_CYCLES`, 16, enabled timesteps ignored after a spike; 0 is legal.
- `TS_WIDTH`, 16, timestamp width.
- `ID_WIDTH`, 8, neuron address width.
- `NEURON_ID`, 0, address placed in every event.
- `FIFO_DEPTH`, 4, event buffer depth; power of 2, at least 2.

Ports:
- `emu_clk`  in  1  emulator clock.
- `emu_rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  timestep enable; `v_in` is sampled only when high.
- `v_in`  in  `V_WIDTH`  signed raw membrane voltage.
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_data`  out  `ID_WIDTH+TS_WIDTH`  `{NEURON_ID, timestamp}`.
- `armed`  out  1  detector is in ARMED.
- `overflow`  out  1  sticky; set when an event is dropped.
- `drop_count`  out  8  dropped events, saturating at 255.

## Operation
- Timestamp counter `ts`:
  - Increments by 1 on every cycle with `en=1`.
  - Wraps modulo 2^`TS_WIDTH`.
  - A spike carries the `ts` value sampled in its detection cycle, before the increment.
- All threshold compares are signed.
- FSM has three states; reset state is ARMED.
  - ARMED: when `en && v_in >= THRESH_HI`, push an event.
    - `REFRAC_CYCLES>0`: go to REFRAC with `rcnt = REFRAC_CYCLES-1`.
    - `REFRAC_CYCLES==0`: go to REARM.
  - REFRAC: on `en`, if `rcnt==0` go to REARM, else decrement `rcnt`. Input is ignored.
  - REARM: when `en && v_in <= THRESH_LO`, go to ARMED. Voltage above `THRESH_HI` in REARM never fires.
- With `en=0`, the FSM, `ts` and `rcnt` hold.
- FIFO:
  - Standard valid/ready stream: a pop happens when `ev_valid && ev_ready`.
  - Push when full and no pop in the same cycle: the event is dropped, `overflow` is set, `drop_count` increments (saturating at 255).
  - Push when full with a pop in the same cycle: the push is accepted.
  - Push and pop together at any other occupancy: both happen, occupancy unchanged.
- `ev_data` is stable while `ev_valid=1 && ev_ready=0`.
- `overflow` and `drop_count` clear only on reset.

## Timing
- Reset values:
  - `ev_valid=0`, `ev_data=0`, `armed=1`, `overflow=0`, `drop_count=0`.
  - Internal: `ts=0`, `rcnt=0`, FIFO empty.
- Latency: with the FIFO empty, a crossing sampled at rising edge N gives `ev_valid=1` after edge N, in cycle N+1.
- Throughput: one push and one pop per cycle.
- Minimum spike spacing is `REFRAC_CYCLES+2` enabled timesteps: spike, refractory, at least one REARM sample, then one ARMED sample.
- `emu_rst` asserted mid-operation:
  - All state clears immediately and asynchronously, and queued events are discarded.
  - The first edge after deassertion is handled as a normal ARMED cycle.

## Structure
- Package `spike_aer_pkg` holds:
  - The FSM state enum `aer_state_t` (ARMED, REFRAC, REARM).
  - The `drop_count` width as a localparam.
  - A function that packs `{id, ts}` into the event word.
- Sub-module `spike_event_fifo` (parameters WIDTH, DEPTH): FWFT, full/empty by pointer-with-wrap-bit, push-when-full-with-pop rule inside. Top level holds the FSM, timestamp, refractory counter and drop statistics.

## Test plan
- Reset, then `v_in` ramps 0 to 1200 with `en=1`, `ev_ready=1`: exactly one event, `ev_data={0, ts at the first sample ≥1000}`, `ev_valid` one cycle after detection.
- `v_in` held at 1200 for 100 cycles: single event. Then drop to 100, then 1200 again: second event only after refractory and re-arm; `armed` rises the cycle after the ≤200 sample.
- `ev_ready=0`, force 6 spike cycles via oscillating `v_in` with `REFRAC_CYCLES=0`:
  - 4 events queued, `overflow=1`, `drop_count=2`.
  - Then `ev_ready=1` drains the events in order with increasing timestamps.
- FIFO full with `ev_ready=1` and a spike arriving the same cycle: no drop, occupancy stays 4.
- `TS_WIDTH=4`: spike at `ts=15`, then next at `ts` after wrap, e.g. 3, reported correctly; `en=0` gaps freeze `ts`.
- Assert `emu_rst` mid-refractory with 2 queued events: outputs take reset values without waiting for a clock edge, and the first post-reset spike carries `ts` equal to the number of enabled cycles since deassertion.

Source files
------------

// File: rtl/spike_aer_pkg.sv
// Shared types and helpers for the spike address-event transmitter.
package spike_aer_pkg;

  // Detector states: ARMED may fire, REFRAC ignores input, REARM waits for a low sample.
  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    REFRAC = 2'd1,
    REARM  = 2'd2
  } aer_state_t;

  // Width of the saturating dropped-event counter.
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Packs {id, ts} into an event word; the caller truncates to ID_WIDTH+TS_WIDTH.
  function automatic logic [63:0] pack_event(input logic [31:0] id,
                                             input logic [31:0] ts,
                                             input int          ts_w);
    return (64'(id) << ts_w) | 64'(ts);
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// First-word-fall-through event buffer. The head word is visible on dout while
// valid is high; a pop removes it. A push while full is accepted only when a pop
// frees the head slot in the same cycle, otherwise it is ignored here and the
// parent accounts for the drop.
module spike_event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra wrap bit tells full (same index, different lap) from empty (identical).
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid   = !empty;
  // Empty buffer presents zero so stale storage never leaks onto the bus.
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; cleared asynchronously so queued events vanish on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_aer_tx.sv
// Spike event transmitter: threshold detector with hysteresis and refractory
// window, timestamp counter, drop statistics and an FWFT event buffer.
// Stream handshake: an event transfers on every cycle where ev_valid and
// ev_ready are both high; ev_data is held while ev_valid is high and ev_ready low.
module spike_aer_tx
  import spike_aer_pkg::*;
#(
  parameter int V_WIDTH       = 25,
  parameter int THRESH_HI     = 1000,
  parameter int THRESH_LO     = 200,
  parameter int REFRAC_CYCLES = 16,
  parameter int TS_WIDTH      = 16,
  parameter int ID_WIDTH      = 8,
  parameter int NEURON_ID     = 0,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                         emu_clk,
  input  logic                         emu_rst,
  input  logic                         en,
  input  logic signed [V_WIDTH-1:0]    v_in,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [ID_WIDTH+TS_WIDTH-1:0] ev_data,
  output logic                         armed,
  output logic                         overflow,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int EV_W = ID_WIDTH + TS_WIDTH;
  localparam int RC_W = (REFRAC_CYCLES < 2) ? 1 : $clog2(REFRAC_CYCLES);
  localparam logic signed [V_WIDTH-1:0] TH_HI = V_WIDTH'(THRESH_HI);
  localparam logic signed [V_WIDTH-1:0] TH_LO = V_WIDTH'(THRESH_LO);
  localparam logic [RC_W-1:0] RC_INIT =
    (REFRAC_CYCLES > 0) ? RC_W'(REFRAC_CYCLES - 1) : '0;

  aer_state_t          state;
  logic [TS_WIDTH-1:0] ts;
  logic [RC_W-1:0]     rcnt;
  logic                fire;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic [EV_W-1:0]     ev_word;

  // Signed compare: a negative membrane voltage must never look like a crossing.
  assign fire    = en && (state == ARMED) && (v_in >= TH_HI);
  assign pop     = ev_valid && ev_ready;
  assign drop    = fire && fifo_full && !pop;
  // The event carries ts as sampled in the detection cycle, before increment.
  assign ev_word = EV_W'(pack_event(32'(ID_WIDTH'(NEURON_ID)), 32'(ts), TS_WIDTH));

  // Detector FSM, timestamp and refractory counter; everything holds while en is low.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state <= ARMED;
      armed <= 1'b1;
      ts    <= '0;
      rcnt  <= '0;
    end else if (en) begin
      ts <= ts + TS_WIDTH'(1);
      case (state)
        ARMED: begin
          if (v_in >= TH_HI) begin
            armed <= 1'b0;
            if (REFRAC_CYCLES > 0) begin
              state <= REFRAC;
              rcnt  <= RC_INIT;
            end else begin
              state <= REARM;
            end
          end
        end
        REFRAC: begin
          if (rcnt == '0) state <= REARM;
          else            rcnt  <= rcnt - RC_W'(1);
        end
        REARM: begin
          if (v_in <= TH_LO) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        default: begin
          state <= ARMED;
          armed <= 1'b1;
        end
      endcase
    end
  end

  // Drop statistics: sticky flag plus saturating counter, cleared only by reset.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != DROP_CNT_MAX) drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

  spike_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (emu_clk),
    .rst   (emu_rst),
    .push  (fire),
    .din   (ev_word),
    .pop   (pop),
    .dout  (ev_data),
    .valid (ev_valid),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_spike_aer_tx.sv
// Bench for spike_aer_tx: instance A uses default parameters, instance B uses
// REFRAC_CYCLES=0, TS_WIDTH=4, NEURON_ID=5 for overflow and wrap scenarios.
module tb_spike_aer_tx;

  logic clk;
  logic rst;

  logic               en_a, ready_a, valid_a, armed_a, ovf_a;
  logic signed [24:0] v_a;
  logic [23:0]        data_a;
  logic [7:0]         drop_a;

  logic               en_b, ready_b, valid_b, armed_b, ovf_b;
  logic signed [24:0] v_b;
  logic [11:0]        data_b;
  logic [7:0]         drop_b;

  int tests;
  int fails;
  int ts_a;
  int ts_b;
  logic [11:0] exp_q[$];

  typedef struct {
    logic        en;
    int          v;
    logic        rdy;
    logic        exp_valid;
    logic [23:0] exp_data;
    logic        exp_armed;
  } vec_t;
  vec_t tab[10];

  spike_aer_tx dut_a (
    .emu_clk(clk), .emu_rst(rst), .en(en_a), .v_in(v_a),
    .ev_valid(valid_a), .ev_ready(ready_a), .ev_data(data_a),
    .armed(armed_a), .overflow(ovf_a), .drop_count(drop_a)
  );

  spike_aer_tx #(.REFRAC_CYCLES(0), .TS_WIDTH(4), .NEURON_ID(5)) dut_b (
    .emu_clk(clk), .emu_rst(rst), .en(en_b), .v_in(v_b),
    .ev_valid(valid_b), .ev_ready(ready_b), .ev_data(data_b),
    .armed(armed_b), .overflow(ovf_b), .drop_count(drop_b)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; the timestamp models count enabled edges, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (en_a) ts_a = (ts_a + 1) & 32'hFFFF;
    if (en_b) ts_b = (ts_b + 1) & 32'hF;
    #1;
  endtask

  task automatic drive_a(input logic e, input int v, input logic r);
    en_a = e; v_a = 25'(v); ready_a = r;
  endtask

  task automatic drive_b(input logic e, input int v, input logic r);
    en_b = e; v_b = 25'(v); ready_b = r;
  endtask

  // Drives B for one edge; when queue_it is set the event {5, ts} is expected.
  task automatic b_step(input logic e, input int v, input logic r, input logic queue_it);
    drive_b(e, v, r);
    if (queue_it) exp_q.push_back({8'd5, 4'(ts_b)});
    tick();
  endtask

  // Drains n events from B with en low, comparing against the expected queue.
  task automatic drain_b(input int n, input string tag);
    en_b = 1'b0; ready_b = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [11:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      check($sformatf("%s valid %0d", tag, i), valid_b, 1);
      check($sformatf("%s data %0d", tag, i), data_b, e);
      tick();
    end
    check({tag, " empty"}, valid_b, 0);
  endtask

  initial begin
    int n_ev, n_arm, t2;
    tests = 0; fails = 0; ts_a = 0; ts_b = 0;
    rst = 1'b1;
    drive_a(0, 0, 1);
    drive_b(0, 0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    check("rst a valid", valid_a, 0);
    check("rst a data", data_a, 0);
    check("rst a armed", armed_a, 1);
    check("rst a overflow", ovf_a, 0);
    check("rst a drops", drop_a, 0);
    check("rst b valid", valid_b, 0);
    check("rst b data", data_b, 0);
    check("rst b armed", armed_b, 1);

    // Ramp on A: crossing at the 1000 sample (ts 5), en=0 sample ignored, backpressure hold.
    tab[0] = '{1'b1,    0, 1'b1, 1'b0, 24'd0, 1'b1};
    tab[1] = '{1'b1,  300, 1'b1, 1'b0, 24'd0, 1'b1};
    tab[2] = '{1'b0, 1200, 1'b1, 1'b0, 24'd0, 1'b1};
    tab[3] = '{1'b1,  600, 1'b1, 1'b0, 24'd0, 1'b1};
    tab[4] = '{1'b1,  900, 1'b1, 1'b0, 24'd0, 1'b1};
    tab[5] = '{1'b1,  999, 1'b1, 1'b0, 24'd0, 1'b1};
    tab[6] = '{1'b1, 1000, 1'b1, 1'b1, 24'd5, 1'b0};
    tab[7] = '{1'b1, 1100, 1'b0, 1'b1, 24'd5, 1'b0};
    tab[8] = '{1'b1, 1200, 1'b1, 1'b0, 24'd0, 1'b0};
    tab[9] = '{1'b0,    0, 1'b1, 1'b0, 24'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive_a(tab[i].en, tab[i].v, tab[i].rdy);
      tick();
      check($sformatf("vec%0d valid", i), valid_a, tab[i].exp_valid);
      check($sformatf("vec%0d armed", i), armed_a, tab[i].exp_armed);
      if (tab[i].exp_valid) check($sformatf("vec%0d data", i), data_a, tab[i].exp_data);
    end

    // Hold high: no further events, stays disarmed.
    n_ev = 0; n_arm = 0;
    drive_a(1, 1200, 1);
    repeat (100) begin
      tick();
      if (valid_a) n_ev++;
      if (armed_a) n_arm++;
    end
    check("hold no event", n_ev, 0);
    check("hold not armed", n_arm, 0);
    drive_a(1, 100, 1); tick();
    check("rearm armed", armed_a, 1);
    check("rearm no event", valid_a, 0);
    t2 = ts_a;
    drive_a(1, 1200, 0); tick();
    check("spike2 valid", valid_a, 1);
    check("spike2 data", data_a, t2);
    check("spike2 armed", armed_a, 0);

    // Exact refractory length: 16 low samples ignored, the 17th re-arms.
    n_arm = 0;
    drive_a(1, 100, 0);
    repeat (16) begin
      tick();
      if (armed_a) n_arm++;
    end
    check("refrac ignores low", n_arm, 0);
    tick();
    check("armed after refrac", armed_a, 1);
    drive_a(1, 1200, 0); tick();
    check("spike3 head valid", valid_a, 1);
    check("spike3 head stable", data_a, t2);
    repeat (5) tick();
    drive_a(0, 0, 0);

    // B: timestamp wrap and en=0 freeze, consumer always ready.
    repeat (15) b_step(1, 0, 1, 0);
    repeat (3) b_step(0, 1200, 1, 0);
    check("b en0 no spike", valid_b, 0);
    b_step(1, 1200, 1, 0);
    check("b ts15 valid", valid_b, 1);
    check("b ts15 data", data_b, 12'h05F);
    check("b ts15 armed", armed_b, 0);
    b_step(1, 100, 1, 0);
    check("b pop valid", valid_b, 0);
    check("b rearm", armed_b, 1);
    repeat (3) b_step(0, 1200, 1, 0);
    check("b en0 armed hold", armed_b, 1);
    check("b en0 no spike 2", valid_b, 0);
    repeat (2) b_step(1, 0, 1, 0);
    b_step(1, 1200, 1, 0);
    check("b wrap valid", valid_b, 1);
    check("b wrap data", data_b, 12'h053);
    b_step(1, 100, 1, 0);

    // B: six spikes into a stalled buffer, two dropped.
    for (int i = 0; i < 6; i++) begin
      b_step(1, 1200, 0, (i < 4));
      b_step(1, 100, 0, 0);
    end
    check("b overflow", ovf_b, 1);
    check("b drop count", drop_b, 2);
    check("b stalled head", data_b, 12'h055);
    drain_b(4, "drain1");

    // B: buffer full, pop and new spike in the same cycle.
    for (int i = 0; i < 4; i++) begin
      b_step(1, 1200, 0, 1);
      b_step(1, 100, 0, 0);
    end
    check("b full no drop", drop_b, 2);
    check("b full head", data_b, exp_q.pop_front());
    b_step(1, 1200, 1, 1);
    check("b full+pop no drop", drop_b, 2);
    drain_b(4, "drain2");
    check("b overflow sticky", ovf_b, 1);

    // Asynchronous reset with A mid-refractory and two events queued.
    #2 rst = 1'b1;
    #1;
    check("async rst a valid", valid_a, 0);
    check("async rst a data", data_a, 0);
    check("async rst a armed", armed_a, 1);
    check("async rst b overflow", ovf_b, 0);
    check("async rst b drops", drop_b, 0);
    ts_a = 0; ts_b = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive_a(1, 0, 1);
    repeat (3) tick();
    drive_a(0, 1200, 1); tick();
    check("post rst en0 no spike", valid_a, 0);
    drive_a(1, 1200, 1); tick();
    check("post rst spike valid", valid_a, 1);
    check("post rst spike data", data_a, 3);
    drive_a(0, 0, 1); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
